// File: rtl/store_buffer_pkg.sv
// Shared sizing defaults and pointer/counter width helpers for the store buffer.
package store_buffer_pkg;

  localparam int unsigned SB_DEPTH_DEF = 4;
  localparam int unsigned SB_AW_DEF    = 32;
  localparam int unsigned SB_DW_DEF    = 32;

  // Word address drops the two byte-offset bits.
  localparam int unsigned SB_BYTE_OFS_W = 2;

  function automatic int unsigned sb_ptr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int unsigned sb_cnt_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/store_buffer_if.sv
// Store, load-probe and data-memory signals of the store buffer, grouped with modports.
interface store_buffer_if
  import store_buffer_pkg::*;
#(
  parameter int unsigned AW = SB_AW_DEF,
  parameter int unsigned DW = SB_DW_DEF
);

  logic          st_valid;
  logic [AW-1:0] st_addr;
  logic [DW-1:0] st_data;
  logic          st_ready;

  logic          ld_valid;
  logic [AW-1:0] ld_addr;
  logic          ld_hit;
  logic [DW-1:0] ld_data;
  logic          ld_stall;

  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack;

  modport master (
    output st_valid, st_addr, st_data, ld_valid, ld_addr, mem_ack,
    input  st_ready, ld_hit, ld_data, ld_stall, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  st_valid, st_addr, st_data, ld_valid, ld_addr, mem_ack,
    output st_ready, ld_hit, ld_data, ld_stall, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/store_buffer_match.sv
// sb_match: compares a load word address against every valid entry; youngest match wins.
module sb_match
  import store_buffer_pkg::*;
#(
  parameter  int unsigned DEPTH = SB_DEPTH_DEF,
  parameter  int unsigned WAW   = SB_AW_DEF - SB_BYTE_OFS_W,
  localparam int unsigned PW    = sb_ptr_w(DEPTH)
) (
  input  logic [DEPTH-1:0][WAW-1:0] entry_addr,
  input  logic [DEPTH-1:0]          valid,
  input  logic [PW-1:0]             wr_ptr,
  input  logic [WAW-1:0]            ld_word,
  output logic                      match,
  output logic [PW-1:0]             hit_idx
);

  // Scan oldest (wr_ptr-DEPTH == wr_ptr) to youngest (wr_ptr-1); later hits override.
  always_comb begin
    match   = 1'b0;
    hit_idx = '0;
    for (int unsigned k = DEPTH; k >= 1; k--) begin
      if (valid[wr_ptr - PW'(k)] && (entry_addr[wr_ptr - PW'(k)] == ld_word)) begin
        match   = 1'b1;
        hit_idx = wr_ptr - PW'(k);
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// store_buffer: FIFO of committed word stores drained to DM, probed by loads.
// Optional feature macro: STORE_BUF_FWD_EN (forward youngest match instead of stalling).
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter  int unsigned DEPTH = SB_DEPTH_DEF,
  parameter  int unsigned AW    = SB_AW_DEF,
  parameter  int unsigned DW    = SB_DW_DEF,
  localparam int unsigned PW    = sb_ptr_w(DEPTH),
  localparam int unsigned CW    = sb_cnt_w(DEPTH)
) (
  input  logic           clk,
  input  logic           reset,
  store_buffer_if.slave  bus,
  output logic           empty,
  output logic [CW-1:0]  count
);

  localparam int unsigned WAW = AW - SB_BYTE_OFS_W;

  logic [DEPTH-1:0][WAW-1:0] ent_addr;
  logic [DEPTH-1:0][DW-1:0]  ent_data;
  logic [DEPTH-1:0]          ent_vld;
  logic [PW-1:0]             wr_ptr;
  logic [PW-1:0]             rd_ptr;
  logic                      full;
  logic                      push;
  logic                      pop;
  logic                      match;
  logic [PW-1:0]             hit_idx;
  logic                      unused_bits;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign push  = bus.st_valid && !full;
  assign pop   = !empty && bus.mem_ack;

  assign bus.st_ready  = !full;
  assign bus.mem_we    = !empty;
  assign bus.mem_addr  = empty ? '0 : {ent_addr[rd_ptr], {SB_BYTE_OFS_W{1'b0}}};
  assign bus.mem_wdata = empty ? '0 : ent_data[rd_ptr];

  // Push and pop never target the same slot: push needs !full, pop needs !empty.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ent_vld <= '0;
    end else begin
      if (push) begin
        ent_vld[wr_ptr] <= 1'b1;
        wr_ptr          <= wr_ptr + 1'b1;
      end
      if (pop) begin
        ent_vld[rd_ptr] <= 1'b0;
        rd_ptr          <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      ent_addr[wr_ptr] <= bus.st_addr[AW-1:SB_BYTE_OFS_W];
      ent_data[wr_ptr] <= bus.st_data;
    end
  end

  sb_match #(
    .DEPTH (DEPTH),
    .WAW   (WAW)
  ) u_match (
    .entry_addr (ent_addr),
    .valid      (ent_vld),
    .wr_ptr     (wr_ptr),
    .ld_word    (bus.ld_addr[AW-1:SB_BYTE_OFS_W]),
    .match      (match),
    .hit_idx    (hit_idx)
  );

`ifdef STORE_BUF_FWD_EN
  assign bus.ld_hit   = bus.ld_valid && match;
  assign bus.ld_data  = bus.ld_hit ? ent_data[hit_idx] : '0;
  assign bus.ld_stall = 1'b0;
  assign unused_bits  = ^{bus.st_addr[SB_BYTE_OFS_W-1:0], bus.ld_addr[SB_BYTE_OFS_W-1:0]};
`else
  assign bus.ld_hit   = 1'b0;
  assign bus.ld_data  = '0;
  assign bus.ld_stall = bus.ld_valid && match;
  assign unused_bits  = ^{bus.st_addr[SB_BYTE_OFS_W-1:0], bus.ld_addr[SB_BYTE_OFS_W-1:0], hit_idx};
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Directed self-checking bench for store_buffer (DEPTH=4); expectations follow STORE_BUF_FWD_EN.
module tb_store_buffer;

`ifdef STORE_BUF_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       empty;
  logic [2:0] count;
  int unsigned total = 0;
  int unsigned bad   = 0;

  always #5 clk = ~clk;

  store_buffer_if #(.AW(32), .DW(32)) bus ();

  store_buffer #(.DEPTH(4), .AW(32), .DW(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .empty (empty),
    .count (count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d);
    bus.st_valid = 1'b1;
    bus.st_addr  = a;
    bus.st_data  = d;
    tick();
    bus.st_valid = 1'b0;
  endtask

  task automatic drain_chk(input string tag, input logic [31:0] a, input logic [31:0] d);
    chk({tag, "_we"}, 32'(bus.mem_we), 32'd1);
    chk({tag, "_addr"}, bus.mem_addr, a);
    chk({tag, "_data"}, bus.mem_wdata, d);
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
  endtask

  task automatic probe(input logic v, input logic [31:0] a);
    bus.ld_valid = v;
    bus.ld_addr  = a;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.st_valid = 1'b0; bus.st_addr = '0; bus.st_data = '0;
    bus.ld_valid = 1'b0; bus.ld_addr = '0; bus.mem_ack = 1'b0;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;

    chk("rst_ready", 32'(bus.st_ready), 32'd1);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_we", 32'(bus.mem_we), 32'd0);
    chk("rst_hit", 32'(bus.ld_hit), 32'd0);
    chk("rst_stall", 32'(bus.ld_stall), 32'd0);
    chk("rst_ldata", bus.ld_data, 32'd0);
    chk("rst_maddr", bus.mem_addr, 32'd0);
    chk("rst_mdata", bus.mem_wdata, 32'd0);

    // Reset with two stores pending
    push(32'h100, 32'h1);
    push(32'h104, 32'h2);
    chk("pre_rst_count", 32'(count), 32'd2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_empty", 32'(empty), 32'd1);
    chk("midrst_count", 32'(count), 32'd0);
    chk("midrst_we", 32'(bus.mem_we), 32'd0);
    chk("midrst_ready", 32'(bus.st_ready), 32'd1);
    chk("midrst_maddr", bus.mem_addr, 32'd0);
    probe(1'b1, 32'h100);
    chk("midrst_stall", 32'(bus.ld_stall), 32'd0);
    chk("midrst_hit", 32'(bus.ld_hit), 32'd0);
    probe(1'b0, 32'h0);

    // Fill, dropped 5th store, in-order drain
    bus.st_valid = 1'b1; bus.st_addr = 32'h10; bus.st_data = 32'hD0;
    #1;
    chk("latency_we", 32'(bus.mem_we), 32'd0);
    tick();
    bus.st_valid = 1'b0;
    chk("first_we", 32'(bus.mem_we), 32'd1);
    chk("first_addr", bus.mem_addr, 32'h10);
    push(32'h14, 32'hD1);
    push(32'h18, 32'hD2);
    push(32'h1C, 32'hD3);
    chk("full_count", 32'(count), 32'd4);
    chk("full_ready", 32'(bus.st_ready), 32'd0);
    push(32'h50, 32'hEE);
    chk("drop_count", 32'(count), 32'd4);
    drain_chk("fill0", 32'h10, 32'hD0);
    drain_chk("fill1", 32'h14, 32'hD1);
    drain_chk("fill2", 32'h18, 32'hD2);
    drain_chk("fill3", 32'h1C, 32'hD3);
    chk("fill_empty", 32'(empty), 32'd1);
    chk("fill_we", 32'(bus.mem_we), 32'd0);

    // Push+pop while full
    push(32'h30, 32'hE0);
    push(32'h34, 32'hE1);
    push(32'h38, 32'hE2);
    push(32'h3C, 32'hE3);
    bus.st_valid = 1'b1; bus.st_addr = 32'h80; bus.st_data = 32'hF0;
    bus.mem_ack = 1'b1;
    #1;
    chk("pp_ready", 32'(bus.st_ready), 32'd0);
    tick();
    bus.st_valid = 1'b0; bus.mem_ack = 1'b0;
    chk("pp_count", 32'(count), 32'd3);
    chk("pp_ready_after", 32'(bus.st_ready), 32'd1);
    push(32'h84, 32'hF4);
    chk("pp_refill", 32'(count), 32'd4);
    drain_chk("pp0", 32'h34, 32'hE1);
    drain_chk("pp1", 32'h38, 32'hE2);
    drain_chk("pp2", 32'h3C, 32'hE3);
    drain_chk("pp3", 32'h84, 32'hF4);
    chk("pp_count_end", 32'(count), 32'd0);

    // Pointer wrap
    for (int i = 0; i < 10; i++) begin
      push(32'(32'h40 + 4 * i), 32'(32'h400 + i));
      drain_chk($sformatf("wrap%0d", i), 32'(32'h40 + 4 * i), 32'(32'h400 + i));
    end
    chk("wrap_count", 32'(count), 32'd0);
    chk("wrap_empty", 32'(empty), 32'd1);

    // Load probes: same-cycle store invisible, youngest match wins
    bus.st_valid = 1'b1; bus.st_addr = 32'h20; bus.st_data = 32'hAAAA;
    probe(1'b1, 32'h20);
    chk("same_cyc_hit", 32'(bus.ld_hit), 32'd0);
    chk("same_cyc_stall", 32'(bus.ld_stall), 32'd0);
    tick();
    bus.st_valid = 1'b0;
    push(32'h20, 32'hBBBB);
    push(32'h30, 32'hCCCC);
    probe(1'b1, 32'h22);
    chk("ld22_hit", 32'(bus.ld_hit), FWD ? 32'd1 : 32'd0);
    chk("ld22_data", bus.ld_data, FWD ? 32'hBBBB : 32'd0);
    chk("ld22_stall", 32'(bus.ld_stall), FWD ? 32'd0 : 32'd1);
    probe(1'b1, 32'h24);
    chk("ld24_hit", 32'(bus.ld_hit), 32'd0);
    chk("ld24_stall", 32'(bus.ld_stall), 32'd0);
    probe(1'b1, 32'h31);
    chk("ld31_data", bus.ld_data, FWD ? 32'hCCCC : 32'd0);
    chk("ld31_stall", 32'(bus.ld_stall), FWD ? 32'd0 : 32'd1);
    probe(1'b0, 32'h20);
    chk("noprobe_stall", 32'(bus.ld_stall), 32'd0);
    chk("noprobe_hit", 32'(bus.ld_hit), 32'd0);

    probe(1'b1, 32'h20);
    bus.mem_ack = 1'b1;
    tick();
    chk("drainA_stall", 32'(bus.ld_stall), FWD ? 32'd0 : 32'd1);
    chk("drainA_data", bus.ld_data, FWD ? 32'hBBBB : 32'd0);
    tick();
    chk("drainB_stall", 32'(bus.ld_stall), 32'd0);
    chk("drainB_hit", 32'(bus.ld_hit), 32'd0);
    chk("drainB_head", bus.mem_addr, 32'h30);
    tick();
    bus.mem_ack = 1'b0;
    probe(1'b0, 32'h0);
    chk("final_empty", 32'(empty), 32'd1);
    chk("final_count", 32'(count), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
